// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and the fetch buffer entry type
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam int              INSN_BYTES       = 4;
  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular buffer of fetched words; entries are allocated at
// issue, filled in response order, popped at the head, and dropped wholesale on flush.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       fill,
  input  logic [XLEN-1:0]            fill_instr,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] alloc_cnt,
  output logic                       head_valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_instr
);

  localparam int             PW    = $clog2(DEPTH);
  localparam int             CW    = $clog2(DEPTH+1);
  localparam logic [PW-1:0]  PTR_1 = PW'(1);
  localparam logic [CW-1:0]  CNT_1 = CW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;

  // Fill only targets allocated-but-unfilled entries and pop only filled ones,
  // so alloc, fill and pop never collide except alloc/pop on a full buffer,
  // where both leave the entry unfilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: NOP_INSN, filled: 1'b0};
      end
    end else if (flush) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        mem[tail_ptr] <= '{pc: alloc_pc, instr: NOP_INSN, filled: 1'b0};
        tail_ptr      <= tail_ptr + PTR_1;
      end
      if (fill) begin
        mem[fill_ptr].instr  <= fill_instr;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + PTR_1;
      end
      if (pop) begin
        mem[head_ptr].filled <= 1'b0;
        head_ptr             <= head_ptr + PTR_1;
      end
      case ({alloc, pop})
        2'b10:   count <= count + CNT_1;
        2'b01:   count <= count - CNT_1;
        default: count <= count;
      endcase
    end
  end

  assign alloc_cnt  = count;
  assign head_valid = (count != '0) && mem[head_ptr].filled;
  assign head_pc    = mem[head_ptr].pc;
  assign head_instr = mem[head_ptr].instr;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: owns the PC, issues in-order word fetches,
// buffers returned words and hands {instr, pc} to decode; redirects squash in-flight work.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc
);

  localparam int            CW    = $clog2(DEPTH+1);
  // After a redirect the buffer is free again while up to DEPTH doomed fetches
  // are still in flight, so the in-flight count can reach 2*DEPTH.
  localparam int            OW    = $clog2(2*DEPTH+1);
  localparam logic [OW-1:0] OUT_1 = OW'(1);

  logic             run;
  logic [WIDTH-1:0] fetch_pc;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    drop_cnt;
  logic [OW-1:0]    out_after_resp;
  logic [OW-1:0]    outstanding_nxt;
  logic [CW-1:0]    alloc_cnt;
  logic             issue;
  logic             resp_fill;
  logic             resp_drop;
  logic             pop;
  logic             head_valid;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_instr;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req  = run && !redirect_valid && (alloc_cnt < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign resp_drop = imem_rvalid && (drop_cnt != '0);
  assign resp_fill = imem_rvalid && (drop_cnt == '0);
  assign pop       = id_valid && id_ready;

  always_comb begin
    out_after_resp  = imem_rvalid ? (outstanding - OUT_1) : outstanding;
    outstanding_nxt = issue ? (out_after_resp + OUT_1) : out_after_resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        drop_cnt <= out_after_resp;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + WIDTH'(INSN_BYTES);
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - OUT_1;
        end
      end
    end
  end

  // A pop in the redirect cycle has already been seen by decode; flush wins afterwards.
  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (issue),
    .alloc_pc  (fetch_pc),
    .fill      (resp_fill),
    .fill_instr(imem_rdata),
    .pop       (pop),
    .flush     (redirect_valid),
    .alloc_cnt (alloc_cnt),
    .head_valid(head_valid),
    .head_pc   (head_pc),
    .head_instr(head_instr)
  );

  assign id_valid = head_valid;
  assign id_instr = head_valid ? head_instr : NOP_INSN;
  assign id_pc    = head_valid ? head_pc : fetch_pc;

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed, table-driven bench for fetch_stage with an in-order memory model
module tb_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  int          n_xfer;
  logic        resp_en;
  logic [31:0] exp_pc;
  logic [31:0] pend[$];
  logic [31:0] iss_q[$];

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F01;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs settled; advances one clock.
  task automatic step();
    #2;
    if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
    if (imem_req && imem_gnt) begin
      pend.push_back(imem_addr);
      iss_q.push_back(imem_addr);
    end
    if (id_valid && id_ready) begin
      n_xfer++;
      chk("xfer_pc", id_pc, exp_pc);
      chk("xfer_instr", id_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    if (resp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    pend.delete();
    iss_q.delete();
    exp_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int xb;
    n_chk = 0; n_err = 0; n_xfer = 0;
    tbl[0] = '{1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3] = '{1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4] = '{1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5] = '{1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6] = '{1'b1, 32'h14, 1'b1, 32'h0C};

    rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; resp_en = 1'b1; exp_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_idv", id_valid, 1'b0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);

    // streaming fetch from reset
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t1_req", imem_req, tbl[i].req);
      if (tbl[i].req) chk("t1_addr", imem_addr, tbl[i].addr);
      chk("t1_idv", id_valid, tbl[i].idv);
      if (tbl[i].idv) begin
        chk("t1_pc", id_pc, tbl[i].pc);
        chk("t1_instr", id_instr, mem_word(tbl[i].pc));
      end else begin
        chk("t1_nop", id_instr, NOP);
      end
      step();
    end

    // decode stall
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i >= 3) begin
        chk("t2_hold_valid", id_valid, 1'b1);
        chk("t2_hold_pc", id_pc, 32'h0);
        chk("t2_hold_instr", id_instr, mem_word(32'h0));
      end
      step();
    end
    chk("t2_issue_count", iss_q.size(), DEPTH);
    #1 chk("t2_req_low", imem_req, 1'b0);
    id_ready = 1'b1;
    xb = n_xfer;
    for (int i = 0; i < 12; i++) step();
    chk("t2_resume", (n_xfer - xb) >= 4, 1'b1);

    // redirect with two fetches in flight
    do_reset();
    resp_en = 1'b0;
    for (int k = 0; k < 10 && iss_q.size() < 2; k++) step();
    chk("t3_two_issued", iss_q.size(), 2);
    iss_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    resp_en        = 1'b1;
    xb             = n_xfer;
    #1 chk("t3_req_blocked", imem_req, 1'b0);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("t3_issued", iss_q.size() > 0, 1'b1);
    if (iss_q.size() > 0) chk("t3_first_addr", iss_q[0], 32'h0000_1000);
    chk("t3_progress", (n_xfer - xb) >= 3, 1'b1);

    // redirect coinciding with a decode transfer
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      if (id_valid) break;
      step();
    end
    chk("t4_valid_before", id_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    xb             = n_xfer;
    step();
    chk("t4_xfer_once", n_xfer - xb, 1);
    #1 chk("t4_valid_after", id_valid, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("t4_progress", (n_xfer - xb) >= 4, 1'b1);

    // PC wrap at the top of the address space
    for (int i = 0; i < 3; i++) step();
    iss_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    xb             = n_xfer;
    step();
    for (int i = 0; i < 12; i++) step();
    chk("t5_issued", iss_q.size() >= 3, 1'b1);
    if (iss_q.size() >= 3) begin
      chk("t5_addr0", iss_q[0], 32'hFFFF_FFFC);
      chk("t5_addr1", iss_q[1], 32'h0000_0000);
      chk("t5_addr2", iss_q[2], 32'h0000_0004);
    end
    chk("t5_no_x", $isunknown(imem_addr), 1'b0);
    chk("t5_progress", (n_xfer - xb) >= 3, 1'b1);

    // asynchronous reset in the middle of traffic
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", imem_req, 1'b0);
    chk("t6_idv", id_valid, 1'b0);
    chk("t6_instr", id_instr, NOP);
    chk("t6_pc", id_pc, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    pend.delete();
    iss_q.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    xb = n_xfer;
    for (int i = 0; i < 10; i++) step();
    chk("t6_restart_issued", iss_q.size() > 0, 1'b1);
    if (iss_q.size() > 0) chk("t6_restart_addr", iss_q[0], 32'h0);
    chk("t6_progress", (n_xfer - xb) >= 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
